divide_share_arbiter: RTL and testbench
=======================================

# divide_share_arbiter

Shares one `divide_int16_int32` divider instance between two AXI-stream requesters, such as the a/(a²+b²) and −b/(a²+b²) paths of a complex inverter built with one divider instead of two. Uses packet-granular round-robin arbitration on the issue side. Records each issued word's requester in an in-order tag FIFO, and uses it to steer divider results back to the correct requester. Sits between the requesters' split/FIFO stages and the divider core.

## Interface
- `MAX_INFLIGHT`, 16: tag FIFO depth; the maximum number of words issued but not yet returned. Must be a power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous flush; same effect as `reset` on arbitration and tag state.
- `i0_tdata`  in  48  requester 0 word: {dividend[15:0], divisor[31:0]}.
- `i0_tlast`, `i0_tvalid`  in  1 each  requester 0 packet end, valid.
- `i0_tready`  out  1  requester 0 ready.
- `i1_tdata`, `i1_tlast`, `i1_tvalid`  in  48/1/1  requester 1, same format.
- `i1_tready`  out  1  requester 1 ready.
- `div_tdata`  out  48  issued {dividend, divisor}, split externally onto the divider's dividend and divisor ports.
- `div_tlast`, `div_tvalid`  out  1 each  issued last, valid.
- `div_tready`  in  1  AND of the divider's dividend and divisor treadys.
- `dout_tdata`  in  48  divider result.
- `dout_tuser`  in  1  divide-by-zero flag.
- `dout_tlast`, `dout_tvalid`  in  1 each  divider result last, valid.
- `dout_tready`  out  1  ready to the divider result port.
- `o0_tdata`, `o0_tuser`, `o0_tlast`, `o0_tvalid`  out  48/1/1/1  result stream to requester 0.
- `o0_tready`  in  1  requester 0 result ready.
- `o1_*`  same as `o0_*`, for requester 1.

## Operation
- **Arbiter FSM states:** IDLE, GRANT0, GRANT1.
- **IDLE:**
  - Only one of `i0_tvalid`/`i1_tvalid` high: grant that requester.
  - Both high: grant the requester that is not `last_grant`.
  - Reset value of `last_grant` is 1, so requester 0 wins the first contest.
- **GRANTn:**
  - `div_tdata`/`div_tlast`/`div_tvalid` = `in_*` passthrough, gated by `!tag_full`.
  - `in_tready = div_tready & !tag_full`.
  - The other requester's tready = 0.
- **Issue handshake** (`div_tvalid & div_tready`):
  - Push n into the tag FIFO.
  - If `in_tlast` is high: set `last_grant` = n and return to IDLE.
- **Return path:**
  - Tag FIFO head h selects the destination.
  - `oh_tvalid = dout_tvalid & !tag_empty`.
  - `oh_tdata`/`oh_tuser`/`oh_tlast` = `dout_*`.
  - `dout_tready = oh_tready`.
  - Pop the tag on the `dout` handshake.
  - The non-selected `o*_tvalid` = 0.
- **Empty tag FIFO with `dout_tvalid` high** (results left in flight after a `clear`): `dout_tready` = 1 and the word is discarded; no `o*_tvalid` is raised.
- **Simultaneous push and pop:** both occur; occupancy is unchanged.
- **Pop from full:** push is allowed in the same cycle.
- **Tag FIFO:** `MAX_INFLIGHT`×1 bit, with read/write pointers of log2(`MAX_INFLIGHT`)+1 bits.
  - full = MSBs differ and the rest equal.
  - empty = pointers equal.
  - Pointers wrap naturally.
- **`reset` or `clear`:**
  - FSM returns to IDLE, `last_grant` = 1, tag pointers = 0.
  - Takes effect even mid-packet; the partial packet's remaining words are then arbitrated as a new packet.

## Timing
- **Reset values:** `i0_tready`, `i1_tready`, `div_tvalid`, `o0_tvalid`, `o1_tvalid` = 0. `dout_tready` = 1 (tag FIFO empty, discard mode).
- **Grant latency:** FSM enters GRANTn one cycle after tvalid is sampled in IDLE. The first transfer can occur in that cycle.
- **Data latency:** the data path adds zero cycles in each direction; issue and return are combinational passthrough. Divider latency is external.
- **Packet-boundary gap:** one idle issue cycle between packets (the IDLE cycle).
- **Throughput:** one word per cycle within a packet.
- **Back-pressure:** `div_tvalid` never depends on `div_tready`. `o*_tvalid` never depends on `o*_tready`.

## Configuration
- Macro: `DIVIDE_SHARE_ZERO_FORCE_EN`.
- **Defined:** when `dout_tuser` = 1, `oN_tdata` is forced to 48'd0; `oN_tuser` still passes through.
- **Undefined:** `dout_tdata` passes unmodified.

## Test plan
- **Reset, then idle:** all tvalid/tready at reset values.
  - Then `i0_tvalid` (3-word packet, dividend 100, divisor 10) → 3 issues.
  - Divider model returns 10 three times → 3 words on `o0`, none on `o1`.
- **Contention fairness:** both requesters continuously send 2-word packets → issue order 0,0,1,1,0,0,1,1. Each result is returned to its originator in order.
- **Tag full:** `MAX_INFLIGHT`=4 with the divider model stalled on output.
  - Exactly 4 words issue, then `div_tvalid` = 0.
  - One `dout` pop → exactly one more issue.
- **Output back-pressure:** `o1_tready` = 0 for 10 cycles while the head tag = 1 → `dout_tready` = 0 and no results are lost. Release → results delivered in order.
- **Clear mid-flight:** assert `clear` with 3 words outstanding.
  - The 3 late results are discarded (`dout_tready` = 1, no `o*_tvalid`).
  - The next packet routes correctly.
- **`DIVIDE_SHARE_ZERO_FORCE_EN` defined:** divisor 0, `dout_tuser` = 1, garbage `dout_tdata` → `o0_tdata` = 0, `o0_tuser` = 1.

Source files
------------

// File: rtl/divide_share_arbiter.sv
// divide_share_arbiter: two AXI-stream requesters share one divider through packet-granular
// round-robin; an in-order tag FIFO steers results back. Option macro: DIVIDE_SHARE_ZERO_FORCE_EN.
module divide_share_arbiter #(
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [47:0] i0_tdata,
    input  logic        i0_tlast,
    input  logic        i0_tvalid,
    output logic        i0_tready,
    input  logic [47:0] i1_tdata,
    input  logic        i1_tlast,
    input  logic        i1_tvalid,
    output logic        i1_tready,
    output logic [47:0] div_tdata,
    output logic        div_tlast,
    output logic        div_tvalid,
    input  logic        div_tready,
    input  logic [47:0] dout_tdata,
    input  logic        dout_tuser,
    input  logic        dout_tlast,
    input  logic        dout_tvalid,
    output logic        dout_tready,
    output logic [47:0] o0_tdata,
    output logic        o0_tuser,
    output logic        o0_tlast,
    output logic        o0_tvalid,
    input  logic        o0_tready,
    output logic [47:0] o1_tdata,
    output logic        o1_tuser,
    output logic        o1_tlast,
    output logic        o1_tvalid,
    input  logic        o1_tready
);
    localparam int unsigned AW = $clog2(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [MAX_INFLIGHT-1:0] tag_q, tag_d;

    logic        tag_full, tag_empty, head, head_ready;
    logic        granted, grant_id, blocked, push, pop;
    logic [47:0] in_tdata;
    logic        in_tlast, in_tvalid;
    logic [47:0] res_tdata;

    assign tag_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tag_empty  = (wr_ptr_q == rd_ptr_q);
    assign head       = tag_q[rd_ptr_q[AW-1:0]];
    assign head_ready = head ? o1_tready : o0_tready;

`ifdef DIVIDE_SHARE_ZERO_FORCE_EN
    assign res_tdata = dout_tuser ? '0 : dout_tdata;
`else
    assign res_tdata = dout_tdata;
`endif

    assign o0_tdata = res_tdata;
    assign o0_tuser = dout_tuser;
    assign o0_tlast = dout_tlast;
    assign o1_tdata = res_tdata;
    assign o1_tuser = dout_tuser;
    assign o1_tlast = dout_tlast;

    always_comb begin
        granted   = (state_q == GRANT0) || (state_q == GRANT1);
        grant_id  = (state_q == GRANT1);
        in_tdata  = grant_id ? i1_tdata  : i0_tdata;
        in_tlast  = grant_id ? i1_tlast  : i0_tlast;
        in_tvalid = grant_id ? i1_tvalid : i0_tvalid;

        // Words returning with no tag were issued before a flush: sink them silently.
        dout_tready = tag_empty | head_ready;
        o0_tvalid   = dout_tvalid & !tag_empty & !head;
        o1_tvalid   = dout_tvalid & !tag_empty & head;
        pop         = dout_tvalid & !tag_empty & head_ready;

        // A pop in the same cycle frees the slot, so a full FIFO does not block issue then.
        blocked    = tag_full & !pop;
        div_tdata  = in_tdata;
        div_tlast  = in_tlast;
        div_tvalid = granted & in_tvalid & !blocked;
        i0_tready  = (state_q == GRANT0) & div_tready & !blocked;
        i1_tready  = (state_q == GRANT1) & div_tready & !blocked;
        push       = div_tvalid & div_tready;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_d        = tag_q;

        case (state_q)
            IDLE: begin
                if (i0_tvalid && i1_tvalid) state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (i0_tvalid)         state_d = GRANT0;
                else if (i1_tvalid)         state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (push && in_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tag_d[wr_ptr_q[AW-1:0]] = grant_id;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
        end
    end
endmodule

// File: tb/tb_divide_share_arbiter.sv
// tb_divide_share_arbiter: directed and random phases against a packet-ownership model,
// a behavioural divider and per-requester result scoreboards.
module tb_divide_share_arbiter;
    localparam int unsigned DEPTH   = 4;
    localparam logic [47:0] GARBAGE = 48'hDEAD_BEEF_CAFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, clear = 1'b0;
    logic [47:0] i0_tdata = '0, i1_tdata = '0;
    logic        i0_tlast = 1'b0, i0_tvalid = 1'b0, i0_tready;
    logic        i1_tlast = 1'b0, i1_tvalid = 1'b0, i1_tready;
    logic [47:0] div_tdata;
    logic        div_tlast, div_tvalid, div_tready = 1'b1;
    logic [47:0] dout_tdata = '0;
    logic        dout_tuser = 1'b0, dout_tlast = 1'b0, dout_tvalid = 1'b0, dout_tready;
    logic [47:0] o0_tdata, o1_tdata;
    logic        o0_tuser, o0_tlast, o0_tvalid, o0_tready = 1'b1;
    logic        o1_tuser, o1_tlast, o1_tvalid, o1_tready = 1'b1;

    divide_share_arbiter #(.MAX_INFLIGHT(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
        .div_tdata(div_tdata), .div_tlast(div_tlast), .div_tvalid(div_tvalid), .div_tready(div_tready),
        .dout_tdata(dout_tdata), .dout_tuser(dout_tuser), .dout_tlast(dout_tlast),
        .dout_tvalid(dout_tvalid), .dout_tready(dout_tready),
        .o0_tdata(o0_tdata), .o0_tuser(o0_tuser), .o0_tlast(o0_tlast), .o0_tvalid(o0_tvalid), .o0_tready(o0_tready),
        .o1_tdata(o1_tdata), .o1_tuser(o1_tuser), .o1_tlast(o1_tlast), .o1_tvalid(o1_tvalid), .o1_tready(o1_tready)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Stimulus sources and behavioural divider
    logic [48:0] src_q [2][$];
    bit          svld [2];
    logic [48:0] divq [$];
    bit          dvld = 1'b0;
    int unsigned src_rate = 100, o_rate = 100, dr_rate = 100, div_rate = 100;
    int          div_budget = -1;
    bit          o_hold [2];

    // Reference model: packet owner (-1 = arbitration cycle), last winner, in-flight tags
    int          owner = -1, last_g = 1;
    int          tagq [$];
    logic [49:0] exp_res [2][$];

    // Observations of the DUT
    int          dut_log [$];
    int          dut_issue = 0, dut_disc = 0;
    int          dut_deliv [2];
    logic [48:0] last_o [2];
    logic [5:0]  obs_vec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] div_model(input logic [47:0] w);
        logic [31:0] dd, dv;
        dd = {16'd0, w[47:32]};
        dv = w[31:0];
        if (dv == 32'd0) return {1'b1, GARBAGE};
        return {1'b0, 16'd0, dd / dv};
    endfunction

    function automatic logic [47:0] exp_data(input logic [48:0] r);
`ifdef DIVIDE_SHARE_ZERO_FORCE_EN
        if (r[48]) return '0;
`endif
        return r[47:0];
    endfunction

    function automatic bit all_idle();
        return src_q[0].size() == 0 && src_q[1].size() == 0 && divq.size() == 0
            && tagq.size() == 0 && owner < 0;
    endfunction

    task automatic drive();
        logic [48:0] r;
        for (int n = 0; n < 2; n++)
            if (!svld[n] && src_q[n].size() > 0 && $urandom_range(99) < src_rate) svld[n] = 1'b1;
        i0_tvalid = svld[0];
        i1_tvalid = svld[1];
        if (svld[0]) {i0_tlast, i0_tdata} = src_q[0][0];
        else         {i0_tlast, i0_tdata} = '0;
        if (svld[1]) {i1_tlast, i1_tdata} = src_q[1][0];
        else         {i1_tlast, i1_tdata} = '0;
        if (!dvld && divq.size() > 0 && div_budget != 0 && $urandom_range(99) < div_rate) dvld = 1'b1;
        dout_tvalid = dvld;
        if (dvld) begin
            r          = div_model(divq[0][47:0]);
            dout_tuser = r[48];
            dout_tdata = r[47:0];
            dout_tlast = divq[0][48];
        end else begin
            dout_tuser = 1'($urandom_range(1));
            dout_tdata = {16'($urandom()), $urandom()};
            dout_tlast = 1'b0;
        end
        o0_tready  = !o_hold[0] && ($urandom_range(99) < o_rate);
        o1_tready  = !o_hold[1] && ($urandom_range(99) < o_rate);
        div_tready = ($urandom_range(99) < dr_rate);
    endtask

    task automatic cycle();
        int          sz, head, own;
        bit          hrdy, pop, room, want, iss, dhs, v0, v1, rs;
        logic [48:0] in_word, r;
        logic [49:0] e;
        @(negedge clk);
        sz      = tagq.size();
        head    = (sz > 0) ? tagq[0] : -1;
        hrdy    = (head == 1) ? o1_tready : o0_tready;
        pop     = dout_tvalid && sz > 0 && hrdy;
        room    = (sz < DEPTH) || pop;
        own     = owner;
        v0      = i0_tvalid;
        v1      = i1_tvalid;
        in_word = (own == 1) ? {i1_tlast, i1_tdata} : {i0_tlast, i0_tdata};
        want    = (own >= 0) && ((own == 1) ? v1 : v0) && room;
        iss     = want && div_tready;
        dhs     = dout_tvalid && (sz == 0 || hrdy);
        rs      = reset || clear;
        obs_vec = {i0_tready, i1_tready, div_tvalid, o0_tvalid, o1_tvalid, dout_tready};
        if (!reset) begin
            chk("div_tvalid", div_tvalid, want);
            chk("i0_tready", i0_tready, own == 0 && div_tready && room);
            chk("i1_tready", i1_tready, own == 1 && div_tready && room);
            chk("dout_tready", dout_tready, sz == 0 || hrdy);
            chk("o0_tvalid", o0_tvalid, dout_tvalid && head == 0);
            chk("o1_tvalid", o1_tvalid, dout_tvalid && head == 1);
            if (want) chk("div_word", {div_tlast, div_tdata}, in_word);
            if (pop) begin
                e = exp_res[head].pop_front();
                if (head == 0) chk("o0_word", {o0_tuser, o0_tdata, o0_tlast}, e);
                else           chk("o1_word", {o1_tuser, o1_tdata, o1_tlast}, e);
            end
            if (i0_tvalid && i0_tready) dut_log.push_back(0);
            if (i1_tvalid && i1_tready) dut_log.push_back(1);
            if (div_tvalid && div_tready) dut_issue++;
            if (o0_tvalid && o0_tready) begin dut_deliv[0]++; last_o[0] = {o0_tuser, o0_tdata}; end
            if (o1_tvalid && o1_tready) begin dut_deliv[1]++; last_o[1] = {o1_tuser, o1_tdata}; end
            if (dout_tvalid && dout_tready && !o0_tvalid && !o1_tvalid) dut_disc++;
        end
        @(posedge clk);
        #1;
        if (iss) begin
            void'(src_q[own].pop_front());
            svld[own] = 1'b0;
            divq.push_back(in_word);
            r = div_model(in_word[47:0]);
            exp_res[own].push_back({r[48], exp_data(r), in_word[48]});
            tagq.push_back(own);
        end
        if (pop) void'(tagq.pop_front());
        if (dhs) begin
            void'(divq.pop_front());
            dvld = 1'b0;
            if (div_budget > 0) div_budget--;
        end
        if (own < 0) begin
            if (v0 && v1)  owner = 1 - last_g;
            else if (v0)   owner = 0;
            else if (v1)   owner = 1;
        end else if (iss && in_word[48]) begin
            last_g = own;
            owner  = -1;
        end
        if (rs) begin
            owner  = -1;
            last_g = 1;
            tagq.delete();
            exp_res[0].delete();
            exp_res[1].delete();
        end
        drive();
    endtask

    task automatic push_pkt(input int n, input int len, input logic [15:0] dd_in,
                            input logic [31:0] dv_in, input bit rnd);
        logic [15:0] dd;
        logic [31:0] dv;
        for (int i = 0; i < len; i++) begin
            dd = dd_in;
            dv = dv_in;
            if (rnd) begin
                dd = 16'($urandom());
                dv = ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(1000, 1));
            end
            src_q[n].push_back({(i == len - 1), dd, dv});
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int k = 0;
        while (!all_idle() && k < maxc) begin
            cycle();
            k++;
        end
        chk(tag, all_idle(), 1'b1);
    endtask

    initial begin
        int base, b0, b1, bd, w0, w1, len;
        dut_deliv[0] = 0;
        dut_deliv[1] = 0;
        last_o[0]    = '0;
        last_o[1]    = '0;
        drive();

        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("reset_values", obs_vec, 6'b000001);

        // Single 3-word packet from requester 0
        push_pkt(0, 3, 16'd100, 32'd10, 1'b0);
        drive();
        drain("p1_drain", 60);
        chk("p1_issues", dut_issue, 3);
        chk("p1_o0_count", dut_deliv[0], 3);
        chk("p1_o1_count", dut_deliv[1], 0);
        chk("p1_o0_result", last_o[0], {1'b0, 48'd10});

        // Contention with 2-word packets after a flush restores the initial priority
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        dut_log.delete();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 2, '0, '0, 1'b1);
            push_pkt(1, 2, '0, '0, 1'b1);
        end
        drive();
        drain("p2_drain", 200);
        chk("p2_log_len", dut_log.size(), 16);
        for (int i = 0; i < 16 && i < dut_log.size(); i++)
            chk($sformatf("p2_order%0d", i), dut_log[i], (i / 2) % 2);

        // Tag FIFO full with the divider output stalled
        base       = dut_issue;
        div_budget = 0;
        push_pkt(0, 6, 16'd500, 32'd7, 1'b0);
        drive();
        repeat (12) cycle();
        chk("p3_issued_at_full", dut_issue - base, 4);
        chk("p3_div_tvalid_full", obs_vec[3], 1'b0);
        div_budget = 1;
        drive();
        repeat (6) cycle();
        chk("p3_issued_after_pop", dut_issue - base, 5);
        chk("p3_div_tvalid_refull", obs_vec[3], 1'b0);
        div_budget = -1;
        drive();
        drain("p3_drain", 60);
        chk("p3_issued_total", dut_issue - base, 6);

        // Output back-pressure on requester 1 with a requester-0 word queued behind it
        b0        = dut_deliv[0];
        b1        = dut_deliv[1];
        o_hold[1] = 1'b1;
        push_pkt(1, 3, '0, '0, 1'b1);
        push_pkt(0, 1, 16'd40, 32'd4, 1'b0);
        drive();
        repeat (10) cycle();
        chk("p4_dout_tready_held", obs_vec[0], 1'b0);
        chk("p4_o1_none", dut_deliv[1] - b1, 0);
        chk("p4_o0_none", dut_deliv[0] - b0, 0);
        o_hold[1] = 1'b0;
        drive();
        drain("p4_drain", 60);
        chk("p4_o1_count", dut_deliv[1] - b1, 3);
        chk("p4_o0_count", dut_deliv[0] - b0, 1);

        // Flush with three words outstanding; their late results must be sunk
        base       = dut_issue;
        div_budget = 0;
        push_pkt(0, 3, '0, '0, 1'b1);
        drive();
        for (int k = 0; k < 20 && dut_issue - base < 3; k++) cycle();
        chk("p5_outstanding", dut_issue - base, 3);
        clear = 1'b1;
        cycle();
        clear      = 1'b0;
        bd         = dut_disc;
        b0         = dut_deliv[0];
        b1         = dut_deliv[1];
        div_budget = -1;
        drive();
        for (int k = 0; k < 30 && divq.size() > 0; k++) cycle();
        chk("p5_discarded", dut_disc - bd, 3);
        chk("p5_no_o0", dut_deliv[0] - b0, 0);
        chk("p5_no_o1", dut_deliv[1] - b1, 0);
        push_pkt(1, 2, '0, '0, 1'b1);
        drive();
        drain("p5_drain", 60);
        chk("p5_o1_after_clear", dut_deliv[1] - b1, 2);
        chk("p5_o0_after_clear", dut_deliv[0] - b0, 0);

        // Divide by zero
        push_pkt(0, 1, 16'h1234, 32'd0, 1'b0);
        drive();
        drain("p6_drain", 40);
`ifdef DIVIDE_SHARE_ZERO_FORCE_EN
        chk("p6_zero_data", last_o[0][47:0], 48'd0);
`else
        chk("p6_zero_data", last_o[0][47:0], GARBAGE);
`endif
        chk("p6_zero_user", last_o[0][48], 1'b1);

        // Random traffic, throttling and back-pressure on every interface
        src_rate = 70;
        o_rate   = 70;
        dr_rate  = 75;
        div_rate = 60;
        b0       = dut_deliv[0];
        b1       = dut_deliv[1];
        w0       = 0;
        w1       = 0;
        for (int p = 0; p < 30; p++) begin
            len = int'($urandom_range(4, 1));
            push_pkt(0, len, '0, '0, 1'b1);
            w0 += len;
            len = int'($urandom_range(4, 1));
            push_pkt(1, len, '0, '0, 1'b1);
            w1 += len;
        end
        drive();
        drain("p7_drain", 3000);
        chk("p7_o0_words", dut_deliv[0] - b0, w0);
        chk("p7_o1_words", dut_deliv[1] - b1, w1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
